// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, next-PC sequencing, busywait stall and sticky misalign flag.
// Define PC_PERF_COUNTERS_EN to add the RETIRED / STALL_CYCLES counters.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        TAKE,
   input  logic [31:0] TARGET,
   input  logic        INSTR_BUSYWAIT,
   input  logic        DATA_BUSYWAIT,
   output logic [31:0] PC,
   output logic [31:0] PC_PLUS4,
   output logic        INSTR_READ,
   output logic        FETCH_VALID,
   output logic        STALLED,
`ifdef PC_PERF_COUNTERS_EN
   output logic [31:0] RETIRED,
   output logic [31:0] STALL_CYCLES,
`endif
   output logic        MISALIGN
);

   localparam logic [1:0] RST_HOLD = 2'd0;
   localparam logic [1:0] RUN      = 2'd1;
   localparam logic [1:0] STALL    = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        misalign_q, misalign_d;
   logic        busy, active, advance;
   logic [31:0] pc_plus4, next_pc;

   always_comb begin
      busy     = INSTR_BUSYWAIT | DATA_BUSYWAIT;
      active   = (state_q == RUN) || (state_q == STALL);
      advance  = active & ~busy;
      pc_plus4 = pc_q + 32'd4;
      // Low target bits are dropped; a nonzero pair is only flagged.
      next_pc  = TAKE ? {TARGET[31:2], 2'b00} : pc_plus4;

      state_d    = state_q;
      pc_d       = pc_q;
      misalign_d = misalign_q;

      unique case (state_q)
         RST_HOLD:   state_d = RUN;
         RUN, STALL: state_d = busy ? STALL : RUN;
         default:    state_d = RST_HOLD;
      endcase

      if (advance) begin
         pc_d       = next_pc;
         misalign_d = misalign_q | (TAKE & (|TARGET[1:0]));
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= RST_HOLD;
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   assign PC          = pc_q;
   assign PC_PLUS4    = pc_plus4;
   assign INSTR_READ  = active;
   assign FETCH_VALID = active & ~INSTR_BUSYWAIT;
   assign STALLED     = (state_q == RST_HOLD) | busy;
   assign MISALIGN    = misalign_q;

`ifdef PC_PERF_COUNTERS_EN
   logic [31:0] retired_q, retired_d;
   logic [31:0] stall_cycles_q, stall_cycles_d;

   always_comb begin
      retired_d      = retired_q + {31'd0, advance};
      stall_cycles_d = stall_cycles_q + {31'd0, active & busy};
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         retired_q      <= 32'd0;
         stall_cycles_q <= 32'd0;
      end else begin
         retired_q      <= retired_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign RETIRED      = retired_q;
   assign STALL_CYCLES = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed vectors feed a scoreboard queue; a monitor pops
// and compares after every clock edge.
module tb_pc_fetch_unit;

   logic        CLK;
   logic        RESET;
   logic        TAKE;
   logic [31:0] TARGET;
   logic        INSTR_BUSYWAIT;
   logic        DATA_BUSYWAIT;
   logic [31:0] PC;
   logic [31:0] PC_PLUS4;
   logic        INSTR_READ;
   logic        FETCH_VALID;
   logic        STALLED;
   logic        MISALIGN;
`ifdef PC_PERF_COUNTERS_EN
   logic [31:0] RETIRED;
   logic [31:0] STALL_CYCLES;
`endif

   pc_fetch_unit #(.RESET_PC(32'd0)) dut (
      .CLK(CLK),
      .RESET(RESET),
      .TAKE(TAKE),
      .TARGET(TARGET),
      .INSTR_BUSYWAIT(INSTR_BUSYWAIT),
      .DATA_BUSYWAIT(DATA_BUSYWAIT),
      .PC(PC),
      .PC_PLUS4(PC_PLUS4),
      .INSTR_READ(INSTR_READ),
      .FETCH_VALID(FETCH_VALID),
      .STALLED(STALLED),
`ifdef PC_PERF_COUNTERS_EN
      .RETIRED(RETIRED),
      .STALL_CYCLES(STALL_CYCLES),
`endif
      .MISALIGN(MISALIGN)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic [31:0] pp4;
      logic        ir;
      logic        fv;
      logic        st;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input int id,
                        input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s vec %0d: got %h want %h", name, id, act, exp);
   endtask

   // Monitor: outputs are sampled 2 time units after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #2;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pc", e.id, PC, e.pc);
            check("pc_plus4", e.id, PC_PLUS4, e.pp4);
            check("instr_read", e.id, {31'd0, INSTR_READ}, {31'd0, e.ir});
            check("fetch_valid", e.id, {31'd0, FETCH_VALID}, {31'd0, e.fv});
            check("stalled", e.id, {31'd0, STALLED}, {31'd0, e.st});
            check("misalign", e.id, {31'd0, MISALIGN}, {31'd0, e.mis});
         end
      end
   end

   int vid = 0;

   task automatic vec(input logic rst, input logic take, input logic [31:0] tgt,
                      input logic ib, input logic db,
                      input logic [31:0] epc, input logic [31:0] epp4,
                      input logic eir, input logic efv, input logic est,
                      input logic emis);
      exp_t e;
      @(negedge CLK);
      RESET          = rst;
      TAKE           = take;
      TARGET         = tgt;
      INSTR_BUSYWAIT = ib;
      DATA_BUSYWAIT  = db;
      vid++;
      e.id  = vid;
      e.pc  = epc;
      e.pp4 = epp4;
      e.ir  = eir;
      e.fv  = efv;
      e.st  = est;
      e.mis = emis;
      sb.push_back(e);
   endtask

   task automatic check_reset_state(input int id);
      check("rst_pc", id, PC, 32'd0);
      check("rst_instr_read", id, {31'd0, INSTR_READ}, 32'd0);
      check("rst_fetch_valid", id, {31'd0, FETCH_VALID}, 32'd0);
      check("rst_stalled", id, {31'd0, STALLED}, 32'd1);
      check("rst_misalign", id, {31'd0, MISALIGN}, 32'd0);
   endtask

   initial begin
      RESET          = 1'b1;
      TAKE           = 1'b0;
      TARGET         = 32'd0;
      INSTR_BUSYWAIT = 1'b0;
      DATA_BUSYWAIT  = 1'b0;
      #1;
      check_reset_state(0);

      // Release and run sequentially: 0 (held), 4, 8, 12.
      vec(0, 0, 32'h0, 0, 0, 32'h0, 32'h4, 1, 1, 0, 0);
      vec(0, 0, 32'h0, 0, 0, 32'h4, 32'h8, 1, 1, 0, 0);
      vec(0, 0, 32'h0, 0, 0, 32'h8, 32'hC, 1, 1, 0, 0);
      vec(0, 0, 32'h0, 0, 0, 32'hC, 32'h10, 1, 1, 0, 0);

      // Instruction stall for 3 edges while a redirect is held.
      vec(0, 1, 32'h80, 1, 0, 32'hC, 32'h10, 1, 0, 1, 0);
      vec(0, 1, 32'h80, 1, 0, 32'hC, 32'h10, 1, 0, 1, 0);
      vec(0, 1, 32'h80, 1, 0, 32'hC, 32'h10, 1, 0, 1, 0);
      vec(0, 1, 32'h80, 0, 0, 32'h80, 32'h84, 1, 1, 0, 0);
`ifdef PC_PERF_COUNTERS_EN
      @(posedge CLK);
      #4;
      check("stall_cycles", vid, STALL_CYCLES, 32'd3);
      check("retired", vid, RETIRED, 32'd4);
`endif
      vec(0, 0, 32'h0, 0, 0, 32'h84, 32'h88, 1, 1, 0, 0);

      // Overlapping data and instruction busywait.
      vec(0, 0, 32'h0, 1, 1, 32'h84, 32'h88, 1, 0, 1, 0);
      vec(0, 0, 32'h0, 0, 1, 32'h84, 32'h88, 1, 1, 1, 0);
      vec(0, 0, 32'h0, 0, 0, 32'h88, 32'h8C, 1, 1, 0, 0);

      // Misaligned redirect: low bits dropped, flag is sticky.
      vec(0, 1, 32'h23, 0, 0, 32'h20, 32'h24, 1, 1, 0, 1);
      vec(0, 0, 32'h0, 0, 0, 32'h24, 32'h28, 1, 1, 0, 1);
      vec(0, 1, 32'h40, 0, 0, 32'h40, 32'h44, 1, 1, 0, 1);

      // Stall at 0x40 with a pending redirect, then async reset mid-stall.
      vec(0, 1, 32'h100, 1, 0, 32'h40, 32'h44, 1, 0, 1, 1);
      @(posedge CLK);
      #4;
      RESET = 1'b1;
      #1;
      check_reset_state(100);

      // Resume from 0 and redirect at PC=8.
      vec(0, 0, 32'h0, 0, 0, 32'h0, 32'h4, 1, 1, 0, 0);
      vec(0, 0, 32'h0, 0, 0, 32'h4, 32'h8, 1, 1, 0, 0);
      vec(0, 0, 32'h0, 0, 0, 32'h8, 32'hC, 1, 1, 0, 0);
      vec(0, 1, 32'h40, 0, 0, 32'h40, 32'h44, 1, 1, 0, 0);
      vec(0, 0, 32'h0, 0, 0, 32'h44, 32'h48, 1, 1, 0, 0);
      vec(0, 0, 32'h0, 0, 0, 32'h48, 32'h4C, 1, 1, 0, 0);

      // Incrementer wraps at the top of the address space.
      vec(0, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 32'h0, 1, 1, 0, 0);
      vec(0, 0, 32'h0, 0, 0, 32'h0, 32'h4, 1, 1, 0, 0);

      repeat (5) @(posedge CLK);
      #4;
      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending want 0", sb.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and drives instruction fetch for the single-cycle CPU.
- Consumes the flow-control decision (taken flag) and the sign-extended branch/jump target, i.e. the consuming end of the PC-redirect interface.
- Sequences the next PC, stalls while the instruction or data cache asserts busywait, and holds a sticky misalignment flag.
- Sits between the control/flow-control logic and the instruction cache.

Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.
- PC_DELAY, 1, time units from CLK posedge to PC register update.
- ADD_DELAY, 1, time units for the PC+4 incrementer.

Ports:
- CLK  input  1  system clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-high reset.
- TAKE  input  1  redirect request from flow control (jump, or branch condition met).
- TARGET  input  32  redirect address (PC+4 plus sign-extended offset<<2).
- INSTR_BUSYWAIT  input  1  instruction cache not ready.
- DATA_BUSYWAIT  input  1  data cache not ready.
- PC  output  32  current fetch address.
- PC_PLUS4  output  32  PC+4, feeds the target adder and the sequential path.
- INSTR_READ  output  1  fetch request to the instruction cache.
- FETCH_VALID  output  1  instruction at PC is valid this cycle.
- STALLED  output  1  core is frozen this cycle.
- MISALIGN  output  1  sticky: a taken TARGET had [1:0] != 0.

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset values: state=RST_HOLD, PC=RESET_PC, INSTR_READ=0, FETCH_VALID=0, STALLED=1, MISALIGN=0.
- PC_PLUS4 = PC + 32'd4, combinational after ADD_DELAY. Carry out of bit 31 is discarded: PC=32'hFFFFFFFC gives PC_PLUS4=0.
- busy = INSTR_BUSYWAIT | DATA_BUSYWAIT.
- States:
  - RST_HOLD: INSTR_READ=0. On the first posedge with RESET low, go to RUN; PC is not updated on that edge, so the instruction at RESET_PC is fetched first.
  - RUN: INSTR_READ=1. If busy at posedge, go to STALL and hold PC. Otherwise load PC with next_pc.
  - STALL: INSTR_READ=1, PC held. At the first posedge with busy=0, load PC with next_pc and return to RUN.
- next_pc = TAKE ? {TARGET[31:2],2'b00} : PC_PLUS4.
- TAKE and TARGET are sampled only on the edge where PC advances. Values presented during stall cycles are ignored until that edge, so a redirect held stable through a stall is honoured exactly once.
- PC update occurs PC_DELAY after the posedge.
- MISALIGN sets on an advancing edge with TAKE=1 and TARGET[1:0]!=0, and clears only on RESET. The low bits are forced to 0 in that case.
- FETCH_VALID = (state!=RST_HOLD) & ~INSTR_BUSYWAIT.
- STALLED = (state==RST_HOLD) | busy.
- Simultaneous events:
  - TAKE with busy=1: hold PC, no redirect.
  - INSTR and DATA busywait together: a single stall, extended until both are low.
- RESET asserted mid-stall or mid-run: immediate asynchronous return to reset values. Any pending redirect is discarded.

Optional Feature:
- Macro: PC_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs RETIRED[31:0] and STALL_CYCLES[31:0], both reset to 0.
  - RETIRED increments on every advancing edge.
  - STALL_CYCLES increments on every posedge in RUN or STALL where busy=1.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset then release, no busy, TAKE=0 for 4 cycles -> PC sequence 0,0,4,8,12. INSTR_READ goes 1 after the first edge. FETCH_VALID=1 from RUN onward.
- At PC=8, TAKE=1, TARGET=32'h40 -> next PC=32'h40, PC_PLUS4=32'h44. With TAKE=0 afterwards, PC steps 32'h44, 32'h48.
- At PC=12, INSTR_BUSYWAIT=1 for 3 cycles with TAKE=1, TARGET=32'h80 -> PC stays 12 and STALLED=1 for 3 cycles. On the release edge PC=32'h80 exactly once (PERF build: STALL_CYCLES=3).
- DATA_BUSYWAIT=1 for 2 cycles overlapping INSTR_BUSYWAIT=1 for 1 cycle -> PC held 2 cycles. FETCH_VALID=0 only during the INSTR_BUSYWAIT cycle.
- TAKE=1, TARGET=32'h23 -> PC=32'h20, MISALIGN=1 and it stays 1 until RESET.
- RESET pulsed asynchronously mid-stall at PC=32'h40 -> PC=0, state RST_HOLD, MISALIGN=0 immediately, with no clock edge required. The normal sequence resumes from 0.
